axi4_dbi_wr_bridge: RTL

- AXI4 write-only slave that turns AXI4 write bursts into a byte/word stream for the DBI TX PHY.
- Generalises the single-window AXI4 write FIFO with:
  - two decoded address windows (pixel data, DBI command), carried to the PHY as a D/CX flag;
  - WSTRB-aware slice filtering;
  - AWLEN/WLAST consistency checking with SLVERR;
  - B-channel back-pressure.
- Sits between the AXI4 interconnect and the DBI TX PHY.

---
 rtl/axi4_dbi_wr_bridge.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_dbi_wr_bridge.sv
// AXI4 write-only slave feeding the DBI TX PHY. It decodes two address windows (pixel data and
// command), drops partially-strobed slices, checks burst length and returns a posted B response.
module axi4_dbi_wr_bridge #(
    parameter int                DATA_W           = 256,
    parameter int                ADDR_W           = 32,
    parameter int                MST_ID_W         = 5,
    parameter int                TRANS_DATA_LEN_W = 8,
    parameter int                TRANS_RESP_W     = 2,
    parameter logic [ADDR_W-1:0] DATA_ADDR        = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] CMD_ADDR         = 32'h2000_0010,
    parameter int                DBI_IF_D_W       = 8,
    parameter int                W_FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // AXI4 AW channel
    input  logic [MST_ID_W-1:0]         m_awid_i,
    input  logic [ADDR_W-1:0]           m_awaddr_i,
    input  logic [TRANS_DATA_LEN_W-1:0] m_awlen_i,
    input  logic                        m_awvalid_i,
    output logic                        m_awready_o,
    // AXI4 W channel
    input  logic [DATA_W-1:0]           m_wdata_i,
    input  logic [DATA_W/8-1:0]         m_wstrb_i,
    input  logic                        m_wlast_i,
    input  logic                        m_wvalid_i,
    output logic                        m_wready_o,
    // AXI4 B channel
    output logic [MST_ID_W-1:0]         m_bid_o,
    output logic [TRANS_RESP_W-1:0]     m_bresp_o,
    output logic                        m_bvalid_o,
    input  logic                        m_bready_i,
    // DBI TX PHY stream
    output logic [DBI_IF_D_W-1:0]       dtp_d_data_o,
    output logic                        dtp_d_dcx_o,
    output logic                        dtp_d_vld_o,
    input  logic                        dtp_d_rdy_i
);

    localparam int STRB_W       = DATA_W / 8;
    localparam int N_SLICE      = DATA_W / DBI_IF_D_W;
    localparam int SLICE_STRB_W = DBI_IF_D_W / 8;
    localparam int P_W          = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam int FIFO_AW      = $clog2(W_FIFO_DEPTH);
    localparam int ENTRY_W      = 1 + STRB_W + DATA_W;

    localparam logic [P_W-1:0]          P_LAST      = P_W'(N_SLICE - 1);
    localparam logic [TRANS_RESP_W-1:0] RESP_OKAY   = '0;
    localparam logic [TRANS_RESP_W-1:0] RESP_SLVERR = TRANS_RESP_W'(2);
    localparam logic [TRANS_RESP_W-1:0] RESP_DECERR = TRANS_RESP_W'(3);

    // ------------------------------------------------------------------
    // AW holding register (one outstanding transaction)
    // ------------------------------------------------------------------
    logic                        aw_full;
    logic                        aw_full_nxt;
    logic                        aw_ready_q;
    logic [MST_ID_W-1:0]         aw_id;
    logic [ADDR_W-1:0]           aw_addr;
    logic [TRANS_DATA_LEN_W-1:0] aw_len;
    logic                        aw_dcx;
    logic                        aw_unmapped;
    logic                        aw_hs;

    assign aw_hs       = m_awvalid_i & aw_ready_q;
    assign aw_dcx      = (aw_addr == DATA_ADDR);
    assign aw_unmapped = ~aw_dcx & (aw_addr != CMD_ADDR);
    assign m_awready_o = aw_ready_q;

    // ------------------------------------------------------------------
    // W acceptance, beat counting and B slot
    // ------------------------------------------------------------------
    logic                        b_valid;
    logic [MST_ID_W-1:0]         b_id;
    logic [TRANS_RESP_W-1:0]     b_resp;
    logic [TRANS_RESP_W-1:0]     b_resp_nxt;
    logic                        b_free;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
    logic                        len_err;
    logic                        beat_err;
    logic                        w_hs;
    logic                        w_last_hs;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;

    assign b_free     = ~b_valid | m_bready_i;
    assign m_wready_o = aw_full & b_free & (~fifo_full | aw_unmapped);
    assign w_hs       = m_wvalid_i & m_wready_o;
    assign w_last_hs  = w_hs & m_wlast_i;
    assign push       = w_hs & ~aw_unmapped;
    assign beat_err   = m_wlast_i ? (beat_cnt != aw_len) : (beat_cnt == aw_len);

    assign m_bvalid_o = b_valid;
    assign m_bid_o    = b_id;
    assign m_bresp_o  = b_resp;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        aw_full_nxt = aw_full;
        b_resp_nxt  = RESP_OKAY;
        if (aw_hs) begin
            aw_full_nxt = 1'b1;
        end else if (w_last_hs) begin
            aw_full_nxt = 1'b0;
        end
        if (aw_unmapped) begin
            b_resp_nxt = RESP_DECERR;
        end else if (len_err | beat_err) begin
            b_resp_nxt = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            aw_full    <= 1'b0;
            aw_ready_q <= 1'b0;
            aw_id      <= '0;
            aw_addr    <= '0;
            aw_len     <= '0;
        end else begin
            aw_full    <= aw_full_nxt;
            aw_ready_q <= ~aw_full_nxt;
            if (aw_hs) begin
                aw_id   <= m_awid_i;
                aw_addr <= m_awaddr_i;
                aw_len  <= m_awlen_i;
            end
        end
    end

    // The length error is sticky so beats running past awlen keep the burst flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else if (w_hs) begin
            if (m_wlast_i) begin
                beat_cnt <= '0;
                len_err  <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_err) begin
                    len_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_id    <= '0;
            b_resp  <= '0;
        end else if (w_last_hs) begin
            b_valid <= 1'b1;
            b_id    <= aw_id;
            b_resp  <= b_resp_nxt;
        end else if (m_bready_i) begin
            b_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // W beat FIFO: {dcx, wstrb, wdata}
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [W_FIFO_DEPTH];
    logic [ENTRY_W-1:0] fifo_head;
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    // NOTE: storage is not reset; the reset pointers alone make every entry invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {aw_dcx, m_wstrb_i, m_wdata_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Unpacker: walks one beat slice by slice, LSB slice first
    // ------------------------------------------------------------------
    logic                    u_valid;
    logic                    u_dcx;
    logic [STRB_W-1:0]       u_strb;
    logic [DATA_W-1:0]       u_data;
    logic [P_W-1:0]          u_p;
    logic [SLICE_STRB_W-1:0] slice_strb;
    logic                    slice_ok;
    logic                    slice_done;

    assign slice_strb = u_strb[u_p*SLICE_STRB_W +: SLICE_STRB_W];
    assign slice_ok   = &slice_strb;
    // Incomplete slices retire on their own; complete ones wait for the PHY.
    assign slice_done = u_valid & (~slice_ok | dtp_d_rdy_i);
    assign pop        = ~fifo_empty & (~u_valid | (slice_done & (u_p == P_LAST)));

    assign dtp_d_vld_o  = u_valid & slice_ok;
    assign dtp_d_data_o = u_data[u_p*DBI_IF_D_W +: DBI_IF_D_W];
    assign dtp_d_dcx_o  = u_dcx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_valid <= 1'b0;
            u_dcx   <= 1'b0;
            u_strb  <= '0;
            u_data  <= '0;
            u_p     <= '0;
        end else if (pop) begin
            u_valid                 <= 1'b1;
            {u_dcx, u_strb, u_data} <= fifo_head;
            u_p                     <= '0;
        end else if (slice_done) begin
            if (u_p == P_LAST) begin
                u_valid <= 1'b0;
                u_p     <= '0;
            end else begin
                u_p <= u_p + 1'b1;
            end
        end
    end

endmodule
